// File: rtl/lsq_issue_ctrl.sv
// lsq_issue_ctrl: picks the oldest eligible load/store queue entry, issues it
// to memory one operation at a time, and dequeues it once it has completed.
// Loads are abandoned on flush. A store that has left IDLE is already
// committed and always runs to completion.
module lsq_issue_ctrl #(
  parameter int N_ENTRIES = 8,
  localparam int PTR_WIDTH = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic [N_ENTRIES-1:0] entry_valid,
  input  logic [N_ENTRIES-1:0] entry_ready,
  input  logic [N_ENTRIES-1:0] entry_is_store,
  input  logic                 store_commit_ok,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [PTR_WIDTH-1:0] mem_req_idx,
  output logic                 mem_req_is_store,
  input  logic                 mem_resp_valid,
  output logic                 deq_ready,
  output logic [N_ENTRIES-1:0] deq_sel_onehot,
  input  logic                 deq_valid,
  output logic                 busy,
  output logic [15:0]          blocked_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DEQ   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   idx_q, idx_d;
  logic                   is_store_q, is_store_d;
  logic [15:0]            blocked_q, blocked_d;
  logic [N_ENTRIES-1:0]   elig_s;
  logic [PTR_WIDTH-1:0]   sel_idx_s;
  logic                   any_elig_s;

  // Eligibility: a store only at the head with commit permission; a load
  // anywhere ahead of the first valid store.
  always_comb begin
    logic seen_store;
    seen_store = 1'b0;
    elig_s     = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i == 0) begin
        elig_s[i] = entry_valid[0] & entry_ready[0] &
                    (entry_is_store[0] ? store_commit_ok : 1'b1);
      end else begin
        elig_s[i] = entry_valid[i] & entry_ready[i] &
                    ~entry_is_store[i] & ~seen_store;
      end
      seen_store = seen_store | (entry_valid[i] & entry_is_store[i]);
    end
  end

  // Lowest-index (oldest) eligible entry wins.
  always_comb begin
    sel_idx_s  = '0;
    any_elig_s = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        sel_idx_s  = PTR_WIDTH'(i);
        any_elig_s = 1'b1;
      end else begin
        any_elig_s = any_elig_s;
      end
    end
  end

  // Next-state, latch and blocked-counter logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    is_store_d = is_store_q;
    blocked_d  = blocked_q;
    case (state_q)
      S_IDLE: begin
        if (any_elig_s && !flush) begin
          state_d    = S_REQ;
          idx_d      = sel_idx_s;
          is_store_d = entry_is_store[sel_idx_s];
        end else if ((|entry_valid) && !any_elig_s && !flush &&
                     (blocked_q != 16'hFFFF)) begin
          blocked_d = blocked_q + 16'd1;
        end else begin
          blocked_d = blocked_q;
        end
      end
      S_REQ: begin
        if (flush && !is_store_q) begin
          state_d = mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (mem_req_ready) begin
          state_d = is_store_q ? S_DEQ : S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (flush && !is_store_q) begin
          state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (mem_resp_valid) begin
          state_d = S_DEQ;
        end else begin
          state_d = S_RESP;
        end
      end
      S_DEQ: begin
        if (flush && !is_store_q) begin
          state_d = S_IDLE;
        end else if (deq_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DEQ;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-entry registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      is_store_q <= 1'b0;
      blocked_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_store_q <= is_store_d;
      blocked_q  <= blocked_d;
    end
  end

  // Outputs decode directly from registered state only.
  assign mem_req_valid    = (state_q == S_REQ);
  assign mem_req_idx      = idx_q;
  assign mem_req_is_store = is_store_q;
  assign deq_ready        = (state_q == S_DEQ);
  assign deq_sel_onehot   = (state_q == S_DEQ) ?
                            ({{(N_ENTRIES-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign busy             = (state_q != S_IDLE);
  assign blocked_cycles   = blocked_q;

endmodule
